// File: rtl/demultiplexor_bcd_pkg.sv
// rtl/demultiplexor_bcd_pkg.sv - shared widths, state encoding and digit helper for the BCD frame demultiplexor
package demultiplexor_bcd_pkg;

  localparam int BUS_DAT            = 12;
  localparam int TAM_REG_BCD_DEF    = BUS_DAT + 4;
  localparam int CANT_PANTALLAS_DEF = TAM_REG_BCD_DEF / 4;

  typedef enum logic {
    ESPERA  = 1'b0,
    CAPTURA = 1'b1
  } estado_t;

  function automatic logic es_cifra_bcd(input logic [3:0] cifra);
    return cifra <= 4'd9;
  endfunction

endpackage

// File: rtl/demultiplexor_bcd_decodificador_pantalla.sv
// rtl/demultiplexor_bcd_decodificador_pantalla.sv - classifies the active-low digit select as blank, single slot or invalid
module decodificador_pantalla
  import demultiplexor_bcd_pkg::*;
#(
  parameter  int CANT_PANTALLAS = CANT_PANTALLAS_DEF,
  localparam int ANCHO_INDICE   = $clog2(CANT_PANTALLAS)
) (
  input  logic [CANT_PANTALLAS-1:0] pantalla,
  output logic [ANCHO_INDICE-1:0]   indice,
  output logic                      es_unico,
  output logic                      es_blanco
);

  int unsigned ceros;

  // Walking downward leaves indice at the lowest low bit; it only matters when es_unico.
  always_comb begin
    ceros  = 0;
    indice = '0;
    for (int k = CANT_PANTALLAS - 1; k >= 0; k--) begin
      if (!pantalla[k]) begin
        ceros  = ceros + 1;
        indice = k[ANCHO_INDICE-1:0];
      end
    end
    es_unico  = (ceros == 1);
    es_blanco = (ceros == 0);
  end

endmodule

// File: rtl/demultiplexor_bcd.sv
// rtl/demultiplexor_bcd.sv - rebuilds a BCD register from a scanned display bus; DEMUX_CHEQUEO_BCD_EN rejects digits above 9
module demultiplexor_bcd
  import demultiplexor_bcd_pkg::*;
#(
  parameter int TAM_REG_BCD    = TAM_REG_BCD_DEF,
  parameter int CANT_PANTALLAS = CANT_PANTALLAS_DEF
) (
  input  logic                      reloj,
  input  logic                      reset,
  input  logic                      muestra,
  input  logic [3:0]                cifraBCD,
  input  logic [CANT_PANTALLAS-1:0] pantalla,
  output logic [TAM_REG_BCD-1:0]    reg_cifrasBCD,
  output logic                      cuadro_valido,
  output logic                      error_secuencia
);

  localparam int ANCHO_INDICE = $clog2(CANT_PANTALLAS);
  localparam logic [ANCHO_INDICE-1:0] ULTIMA = ANCHO_INDICE'(CANT_PANTALLAS - 1);
  localparam logic [ANCHO_INDICE-1:0] UNO    = ANCHO_INDICE'(1);

  estado_t                  estado;
  logic [ANCHO_INDICE-1:0]  esperado;
  logic [ANCHO_INDICE-1:0]  indice;
  logic [TAM_REG_BCD-1:0]   sombra;
  logic [TAM_REG_BCD-1:0]   sombra_nueva;
  logic                     es_unico;
  logic                     es_blanco;
  logic                     cifra_ok;
  logic                     es_esperado;
  logic                     es_repetido;

  decodificador_pantalla #(
    .CANT_PANTALLAS (CANT_PANTALLAS)
  ) u_decodificador (
    .pantalla  (pantalla),
    .indice    (indice),
    .es_unico  (es_unico),
    .es_blanco (es_blanco)
  );

  always_comb begin
`ifdef DEMUX_CHEQUEO_BCD_EN
    cifra_ok = es_cifra_bcd(cifraBCD);
`else
    cifra_ok = 1'b1;
`endif
    sombra_nueva = sombra;
    sombra_nueva[{esperado, 2'b00} +: 4] = cifraBCD;
    es_esperado = es_unico && (indice == esperado) && cifra_ok;
    // A slow scan may present the slot just taken for a second sample.
    es_repetido = es_unico && (indice == esperado - UNO);
  end

  always_ff @(posedge reloj) begin
    cuadro_valido   <= 1'b0;
    error_secuencia <= 1'b0;
    if (reset) begin
      estado        <= ESPERA;
      esperado      <= '0;
      sombra        <= '0;
      reg_cifrasBCD <= '0;
    end else if (muestra) begin
      case (estado)
        ESPERA: begin
          // esperado is always zero here, so sombra_nueva targets nibble 0.
          if (es_esperado) begin
            sombra   <= sombra_nueva;
            esperado <= UNO;
            estado   <= CAPTURA;
          end
        end
        CAPTURA: begin
          if (es_esperado) begin
            sombra <= sombra_nueva;
            if (esperado == ULTIMA) begin
              reg_cifrasBCD <= sombra_nueva;
              cuadro_valido <= 1'b1;
              esperado      <= '0;
              estado        <= ESPERA;
            end else begin
              esperado <= esperado + UNO;
            end
          end else if (!(es_blanco || es_repetido)) begin
            error_secuencia <= 1'b1;
            sombra          <= '0;
            esperado        <= '0;
            estado          <= ESPERA;
          end
        end
        default: begin
          esperado <= '0;
          estado   <= ESPERA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demultiplexor_bcd.sv
// tb/tb_demultiplexor_bcd.sv - scoreboard bench for demultiplexor_bcd with directed frames and random scan traffic
module tb_demultiplexor_bcd;

  localparam int N   = 4;
  localparam int TAM = 16;

  logic           reloj = 1'b0;
  logic           reset;
  logic           muestra;
  logic [3:0]     cifraBCD;
  logic [N-1:0]   pantalla;
  logic [TAM-1:0] reg_cifrasBCD;
  logic           cuadro_valido;
  logic           error_secuencia;

  always #5 reloj = ~reloj;

  demultiplexor_bcd #(
    .TAM_REG_BCD    (TAM),
    .CANT_PANTALLAS (N)
  ) dut (
    .reloj           (reloj),
    .reset           (reset),
    .muestra         (muestra),
    .cifraBCD        (cifraBCD),
    .pantalla        (pantalla),
    .reg_cifrasBCD   (reg_cifrasBCD),
    .cuadro_valido   (cuadro_valido),
    .error_secuencia (error_secuencia)
  );

  typedef struct packed {
    logic           cv;
    logic           err;
    logic [TAM-1:0] regv;
  } evento_t;

  evento_t        cola[$];
  evento_t        pendiente[$];
  int             checks = 0;
  int             passes = 0;
  bit             activo = 1'b0;
  logic [TAM-1:0] reg_esperado;

  int             m_siguiente;
  bit             m_capturando;
  int             m_cifras[N];
  logic [TAM-1:0] m_reg;

  task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] requerido);
    checks++;
    if (actual === requerido) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nombre, actual, requerido);
  endtask

  function automatic bit cifra_aceptable(input int c);
`ifdef DEMUX_CHEQUEO_BCD_EN
    return c <= 9;
`else
    return 1'b1;
`endif
  endfunction

  task automatic modelo(input bit rst, input bit mu, input logic [N-1:0] pant, input logic [3:0] cif);
    int ceros;
    int k;
    if (rst) begin
      m_capturando = 1'b0;
      m_siguiente  = 0;
      m_reg        = '0;
      foreach (m_cifras[i]) m_cifras[i] = 0;
      return;
    end
    if (!mu) return;
    ceros = 0;
    k     = -1;
    for (int i = 0; i < N; i++) begin
      if (!pant[i]) begin
        ceros++;
        if (k < 0) k = i;
      end
    end
    if (!m_capturando) begin
      if (ceros == 1 && k == 0 && cifra_aceptable(int'(cif))) begin
        m_cifras[0]  = int'(cif);
        m_siguiente  = 1;
        m_capturando = 1'b1;
      end
    end else if (ceros == 1 && k == m_siguiente && cifra_aceptable(int'(cif))) begin
      m_cifras[k] = int'(cif);
      if (k == N - 1) begin
        m_reg = '0;
        for (int i = N - 1; i >= 0; i--) m_reg = TAM'(m_reg * 16 + m_cifras[i]);
        pendiente.push_back('{cv: 1'b1, err: 1'b0, regv: m_reg});
        m_capturando = 1'b0;
        m_siguiente  = 0;
      end else begin
        m_siguiente++;
      end
    end else if (!(ceros == 0 || (ceros == 1 && k == m_siguiente - 1))) begin
      pendiente.push_back('{cv: 1'b0, err: 1'b1, regv: m_reg});
      m_capturando = 1'b0;
      m_siguiente  = 0;
    end
  endtask

  task automatic ciclo(input bit rst, input bit mu, input logic [N-1:0] pant, input logic [3:0] cif);
    reset    = rst;
    muestra  = mu;
    pantalla = pant;
    cifraBCD = cif;
    modelo(rst, mu, pant, cif);
    @(posedge reloj);
    #1;
    while (pendiente.size() != 0) cola.push_back(pendiente.pop_front());
    reg_esperado = m_reg;
  endtask

  task automatic muestra_slot(input int slot, input logic [3:0] d);
    ciclo(1'b0, 1'b1, ~(N'(1) << slot), d);
  endtask

  task automatic inactivo(input int n);
    for (int i = 0; i < n; i++) ciclo(1'b0, 1'b0, '1, 4'd0);
  endtask

  initial begin
    evento_t e;
    forever begin
      @(negedge reloj);
      if (activo) begin
        check("reg_hold", reg_cifrasBCD, reg_esperado);
        check("pulses_exclusive", cuadro_valido & error_secuencia, 0);
        if (cuadro_valido || error_secuencia) begin
          if (cola.size() == 0) begin
            check("unexpected_pulse", {cuadro_valido, error_secuencia}, 0);
          end else begin
            e = cola.pop_front();
            check("cuadro_valido", cuadro_valido, e.cv);
            check("error_secuencia", error_secuencia, e.err);
            check("reg_at_pulse", reg_cifrasBCD, e.regv);
          end
        end else if (cola.size() != 0) begin
          e = cola.pop_front();
          check("missing_pulse", {cuadro_valido, error_secuencia}, {e.cv, e.err});
        end
      end
    end
  end

  initial begin
    int         r;
    int         slot;
    logic [3:0] d;
    logic [15:0] esperado_a;
    reset    = 1'b1;
    muestra  = 1'b0;
    pantalla = '1;
    cifraBCD = 4'd0;
    ciclo(1'b1, 1'b0, '1, 4'd0);
    ciclo(1'b1, 1'b1, 4'b1110, 4'd7);
    check("reset_reg", reg_cifrasBCD, 0);
    check("reset_cv", cuadro_valido, 0);
    check("reset_err", error_secuencia, 0);
    activo = 1'b1;

    for (int i = 0; i < 4; i++) muestra_slot(i, 4'(i + 1));
    inactivo(2);
    check("frame_4321", reg_cifrasBCD, 16'h4321);

    muestra_slot(2, 4'd9);
    for (int i = 0; i < 4; i++) muestra_slot(i, 4'(i + 5));
    inactivo(2);
    check("frame_8765", reg_cifrasBCD, 16'h8765);

    muestra_slot(0, 4'd1);
    muestra_slot(1, 4'd2);
    ciclo(1'b0, 1'b1, 4'b1100, 4'd3);
    inactivo(2);
    check("two_low_keeps_reg", reg_cifrasBCD, 16'h8765);

    muestra_slot(0, 4'd1);
    muestra_slot(1, 4'd2);
    muestra_slot(3, 4'd4);
    muestra_slot(0, 4'd9);
    muestra_slot(1, 4'd0);
    muestra_slot(2, 4'd9);
    muestra_slot(3, 4'd0);
    inactivo(2);
    check("frame_0909", reg_cifrasBCD, 16'h0909);

    muestra_slot(0, 4'd1);
    muestra_slot(1, 4'hA);
    muestra_slot(2, 4'd3);
    muestra_slot(3, 4'd4);
    inactivo(2);
`ifdef DEMUX_CHEQUEO_BCD_EN
    esperado_a = 16'h0909;
`else
    esperado_a = 16'h43A1;
`endif
    check("digit_a_frame", reg_cifrasBCD, esperado_a);

    muestra_slot(0, 4'd1);
    muestra_slot(1, 4'd2);
    ciclo(1'b1, 1'b1, 4'b1011, 4'd3);
    check("reset_mid_frame", reg_cifrasBCD, 0);
    for (int i = 0; i < 4; i++) muestra_slot(i, 4'(i + 1));
    inactivo(2);
    check("frame_after_reset", reg_cifrasBCD, 16'h4321);

    muestra_slot(0, 4'd6);
    muestra_slot(0, 4'd6);
    muestra_slot(1, 4'd5);
    ciclo(1'b0, 1'b0, 4'b1110, 4'd0);
    muestra_slot(1, 4'd5);
    ciclo(1'b0, 1'b1, 4'b1111, 4'd0);
    muestra_slot(2, 4'd4);
    muestra_slot(2, 4'd4);
    muestra_slot(3, 4'd3);
    inactivo(2);
    check("slow_scan_frame", reg_cifrasBCD, 16'h3456);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      d = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
      if (r < 1) begin
        ciclo(1'b1, 1'($urandom_range(1)), N'($urandom), d);
      end else if (r < 20) begin
        ciclo(1'b0, 1'b0, N'($urandom), d);
      end else if (r < 60) begin
        muestra_slot(m_siguiente, d);
      end else if (r < 70) begin
        ciclo(1'b0, 1'b1, '1, d);
      end else if (r < 78) begin
        slot = (m_siguiente > 0) ? m_siguiente - 1 : 0;
        muestra_slot(slot, d);
      end else begin
        ciclo(1'b0, 1'b1, N'($urandom), d);
      end
    end

    inactivo(3);
    check("queue_drained", cola.size() + pendiente.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
